// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//  Shared constants for the instruction-fetch front end: FSM state encoding,
//  PC increment, reset values and the sequential-PC helper.
// ----------------------------------------------------------------------------
package fetch_pkg;

    // FSM state encoding (plain constants so older tools and dumps decode it)
    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_VALID = 2'd3;

    localparam logic [31:0] PC_INC   = 32'd4;
    localparam logic [31:0] RST_WORD = 32'h0000_0000;

    // Sequential successor; 32-bit arithmetic, so 0xFFFF_FFFC wraps to 0x0.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// ----------------------------------------------------------------------------
// fetch_perf_cnt
//  One saturating event counter for the fetch front end. Only built when
//  FETCH_PERF_CNT_EN is defined.
//  Ports:
//   i_clk  clock
//   i_rst  asynchronous active-high reset, clears the count
//   i_inc  count one event this cycle
//   o_cnt  current count, sticks at all-ones
// ----------------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_cnt #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cnt <= '0;
        end else if (i_inc && (o_cnt != {W{1'b1}})) begin
            o_cnt <= o_cnt + W'(1);
        end
    end

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//  IF-stage front-end controller. Owns the fetch PC, runs a single-outstanding
//  req/ack handshake to instruction memory, presents the fetched word and its
//  PC to IF (held across stalls), and picks the next PC with priority
//  mispredict recovery > predicted jump > PC+4. Fetches orphaned by a flush
//  are drained and their data discarded.
//  Optional feature macro: FETCH_PERF_CNT_EN adds three saturating perf
//  counters (accepted acks, accepted flushes, stalled-valid cycles).
//  Ports:
//   i_clk, i_rst            clock; asynchronous active-high reset
//   o_imem_req/o_imem_addr  fetch request and address (stable while req=1)
//   i_imem_ack/i_imem_rdata response strobe and instruction word
//   o_ins_valid/o_ins/o_pc  instruction presented to IF
//   i_stall                 IF does not consume the presented instruction
//   i_jump/i_pc_br          take i_pc_br as next PC (only while valid)
//   i_miss/i_redir_pc       mispredict flush and recovery PC
//   o_fetch_cnt/o_flush_cnt/o_stall_cnt  perf counters (FETCH_PERF_CNT_EN)
// ----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_imem_req,
    output logic [31:0]      o_imem_addr,
    input  logic             i_imem_ack,
    input  logic [31:0]      i_imem_rdata,
    output logic             o_ins_valid,
    output logic [31:0]      o_ins,
    output logic [31:0]      o_pc,
    input  logic             i_stall,
    input  logic             i_jump,
    input  logic [31:0]      i_pc_br,
    input  logic             i_miss,
`ifdef FETCH_PERF_CNT_EN
    input  logic [31:0]      i_redir_pc,
    output logic [CNT_W-1:0] o_fetch_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic [CNT_W-1:0] o_stall_cnt
`else
    input  logic [31:0]      i_redir_pc
`endif
);

    logic [1:0]  state;
    logic [31:0] fetch_pc;   // where the next request will go
    logic [31:0] req_addr;   // address of the request on the bus
    logic        req_gap;    // one idle cycle after a flush hit a returning ack
    logic [31:0] consume_pc; // next PC when the presented instruction retires
    logic [31:0] redirect_pc;

    assign o_imem_req  = ((state == S_REQ) && !req_gap) || (state == S_DRAIN);
    assign o_imem_addr = req_addr;
    assign o_ins_valid = (state == S_VALID);

    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        consume_pc  = next_seq_pc(o_pc);
        redirect_pc = fetch_pc;
        if (i_miss) begin
            consume_pc  = i_redir_pc;
            redirect_pc = i_redir_pc;
        end else if (i_jump) begin
            consume_pc  = i_pc_br;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_BOOT;
            fetch_pc <= RESET_PC;
            req_addr <= RST_WORD;
            req_gap  <= 1'b0;
            o_ins    <= RST_WORD;
            o_pc     <= RST_WORD;
        end else begin
            case (state)
                S_BOOT: begin
                    req_addr <= fetch_pc;
                    state    <= S_REQ;
                end

                S_REQ: begin
                    if (req_gap) begin
                        // Request is low this cycle; any ack is stray. A flush
                        // here still retargets the upcoming request.
                        req_gap  <= 1'b0;
                        req_addr <= redirect_pc;
                        fetch_pc <= redirect_pc;
                    end else if (i_imem_ack) begin
                        if (i_miss) begin
                            fetch_pc <= i_redir_pc;
                            req_gap  <= 1'b1;
                        end else begin
                            o_ins <= i_imem_rdata;
                            o_pc  <= req_addr;
                            state <= S_VALID;
                        end
                    end else if (i_miss) begin
                        // The old request is still in flight; wait it out.
                        fetch_pc <= i_redir_pc;
                        state    <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    fetch_pc <= redirect_pc;
                    if (i_imem_ack) begin
                        req_addr <= redirect_pc;
                        state    <= S_REQ;
                    end
                end

                S_VALID: begin
                    if (i_miss || !i_stall) begin
                        fetch_pc <= consume_pc;
                        req_addr <= consume_pc;
                        state    <= S_REQ;
                    end
                end

                default: state <= S_BOOT;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic ev_fetch;
    logic ev_flush;
    logic ev_stall;

    assign ev_fetch = i_imem_ack && o_imem_req;
    assign ev_flush = i_miss && (state != S_BOOT);
    assign ev_stall = i_stall && (state == S_VALID);

    fetch_perf_cnt #(.W(CNT_W)) u_fetch_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (ev_fetch),
        .o_cnt (o_fetch_cnt)
    );

    fetch_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (ev_flush),
        .o_cnt (o_flush_cnt)
    );

    fetch_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (ev_stall),
        .o_cnt (o_stall_cnt)
    );
`else
    logic cnt_w_unused;
    assign cnt_w_unused = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
//  Directed, table-driven bench for fetch_sequencer with RESET_PC=0x100.
//  Each table row is one clock cycle: the inputs driven during the cycle and
//  the outputs expected at the start of it. Reset behaviour is exercised by
//  hand-written sequences afterwards.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          CW     = 32;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        stall;
    logic        jump;
    logic [31:0] pc_br;
    logic        miss;
    logic [31:0] redir_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [CW-1:0] fetch_cnt;
    logic [CW-1:0] flush_cnt;
    logic [CW-1:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    fetch_sequencer #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ack   (imem_ack),
        .i_imem_rdata (imem_rdata),
        .o_ins_valid  (ins_valid),
        .o_ins        (ins),
        .o_pc         (pc),
        .i_stall      (stall),
        .i_jump       (jump),
        .i_pc_br      (pc_br),
        .i_miss       (miss),
`ifdef FETCH_PERF_CNT_EN
        .i_redir_pc   (redir_pc),
        .o_fetch_cnt  (fetch_cnt),
        .o_flush_cnt  (flush_cnt),
        .o_stall_cnt  (stall_cnt)
`else
        .i_redir_pc   (redir_pc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        jump;
        logic [31:0] br;
        logic        miss;
        logic [31:0] redir;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_ins;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vec [27];

    function automatic vec_t mk(
        input logic ack, input logic [31:0] rdata, input logic st,
        input logic jp, input logic [31:0] br, input logic ms,
        input logic [31:0] rd, input logic e_req, input logic [31:0] e_addr,
        input logic e_val, input logic [31:0] e_ins, input logic [31:0] e_pc);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.stall = st; v.jump = jp; v.br = br;
        v.miss = ms; v.redir = rd; v.e_req = e_req; v.e_addr = e_addr;
        v.e_val = e_val; v.e_ins = e_ins; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_req,
                              input logic [31:0] e_addr, input logic e_val,
                              input logic [31:0] e_ins, input logic [31:0] e_pc);
        check({tag, ".req"},   32'(imem_req),  32'(e_req));
        check({tag, ".addr"},  imem_addr,      e_addr);
        check({tag, ".valid"}, 32'(ins_valid), 32'(e_val));
        check({tag, ".ins"},   ins,            e_ins);
        check({tag, ".pc"},    pc,             e_pc);
    endtask

    task automatic idle_inputs();
        imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0; jump = 1'b0;
        pc_br = 32'h0; miss = 1'b0; redir_pc = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ack rdata      st jp br            ms redir         | req addr          val ins           pc
        vec[0]  = mk(0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   0, 32'h0,        0, 32'h0,        32'h0);
        vec[1]  = mk(0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   1, 32'h100,      0, 32'h0,        32'h0);
        vec[2]  = mk(1, 32'h13,       0, 0, 32'h0,        0, 32'h0,   1, 32'h100,      0, 32'h0,        32'h0);
        vec[3]  = mk(0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   0, 32'h100,      1, 32'h13,       32'h100);
        vec[4]  = mk(1, 32'h00A00093, 0, 0, 32'h0,        0, 32'h0,   1, 32'h104,      0, 32'h13,       32'h100);
        vec[5]  = mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0,   0, 32'h104,      1, 32'h00A00093, 32'h104);
        vec[6]  = mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0,   0, 32'h104,      1, 32'h00A00093, 32'h104);
        vec[7]  = mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0,   0, 32'h104,      1, 32'h00A00093, 32'h104);
        vec[8]  = mk(0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   0, 32'h104,      1, 32'h00A00093, 32'h104);
        vec[9]  = mk(1, 32'h6F,       0, 0, 32'h0,        0, 32'h0,   1, 32'h108,      0, 32'h00A00093, 32'h104);
        vec[10] = mk(0, 32'h0,        0, 1, 32'h200,      0, 32'h0,   0, 32'h108,      1, 32'h6F,       32'h108);
        vec[11] = mk(0, 32'h0,        0, 0, 32'h0,        1, 32'h300, 1, 32'h200,      0, 32'h6F,       32'h108);
        vec[12] = mk(0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   1, 32'h200,      0, 32'h6F,       32'h108);
        vec[13] = mk(0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   1, 32'h200,      0, 32'h6F,       32'h108);
        vec[14] = mk(1, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h0,   1, 32'h200,      0, 32'h6F,       32'h108);
        vec[15] = mk(1, 32'h11111111, 0, 0, 32'h0,        1, 32'h400, 1, 32'h300,      0, 32'h6F,       32'h108);
        vec[16] = mk(1, 32'h99999999, 0, 0, 32'h0,        0, 32'h0,   0, 32'h300,      0, 32'h6F,       32'h108);
        vec[17] = mk(1, 32'h22222222, 0, 0, 32'h0,        0, 32'h0,   1, 32'h400,      0, 32'h6F,       32'h108);
        vec[18] = mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0,   0, 32'h400,      1, 32'h22222222, 32'h400);
        vec[19] = mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h500, 0, 32'h400,      1, 32'h22222222, 32'h400);
        vec[20] = mk(1, 32'h33333333, 0, 0, 32'h0,        0, 32'h0,   1, 32'h500,      0, 32'h22222222, 32'h400);
        vec[21] = mk(0, 32'h0,        0, 1, 32'hFFFFFFFC, 0, 32'h0,   0, 32'h500,      1, 32'h33333333, 32'h500);
        vec[22] = mk(1, 32'h44444444, 0, 0, 32'h0,        0, 32'h0,   1, 32'hFFFFFFFC, 0, 32'h33333333, 32'h500);
        vec[23] = mk(1, 32'h77777777, 0, 0, 32'h0,        0, 32'h0,   0, 32'hFFFFFFFC, 1, 32'h44444444, 32'hFFFFFFFC);
        vec[24] = mk(1, 32'h55,       0, 0, 32'h0,        0, 32'h0,   1, 32'h0,        0, 32'h44444444, 32'hFFFFFFFC);
        vec[25] = mk(0, 32'h0,        0, 1, 32'h203,      0, 32'h0,   0, 32'h0,        1, 32'h55,       32'h0);
        vec[26] = mk(0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   1, 32'h203,      0, 32'h55,       32'h0);

        rst = 1'b1;
        idle_inputs();
        step();
        check_outs("in_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        rst = 1'b0;

        // Table: each row checks outputs, then applies its inputs for one edge.
        for (int i = 0; i < 27; i++) begin
            imem_ack   = vec[i].ack;
            imem_rdata = vec[i].rdata;
            stall      = vec[i].stall;
            jump       = vec[i].jump;
            pc_br      = vec[i].br;
            miss       = vec[i].miss;
            redir_pc   = vec[i].redir;
            check_outs($sformatf("v%0d", i), vec[i].e_req, vec[i].e_addr,
                       vec[i].e_val, vec[i].e_ins, vec[i].e_pc);
            step();
        end
        idle_inputs();

        // Still waiting on the unaligned request to 0x203.
        check_outs("tail", 1'b1, 32'h203, 1'b0, 32'h55, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("cnt.fetch", fetch_cnt, 32'd9);
        check("cnt.flush", flush_cnt, 32'd3);
        check("cnt.stall", stall_cnt, 32'd5);
`endif

        // Reset mid-request: outputs clear without waiting for an edge.
        #2 rst = 1'b1;
        #1 check_outs("rst_req", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("rst.fetch", fetch_cnt, 32'd0);
        check("rst.flush", flush_cnt, 32'd0);
        check("rst.stall", stall_cnt, 32'd0);
`endif
        step();
        rst = 1'b0;

        // A flush during boot is ignored; first request still goes to RESET_PC.
        miss = 1'b1; redir_pc = 32'h700;
        check_outs("boot", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        idle_inputs();
        check_outs("boot_req", 1'b1, RST_PC, 1'b0, 32'h0, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
        step();
        idle_inputs();
        stall = 1'b1;
        check_outs("boot_val", 1'b0, RST_PC, 1'b1, 32'hAAAA_5555, RST_PC);
        step();
        check_outs("boot_stall", 1'b0, RST_PC, 1'b1, 32'hAAAA_5555, RST_PC);

        // Reset mid-stall.
        #2 rst = 1'b1;
        #1 check_outs("rst_stall", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        rst = 1'b0;
        idle_inputs();
        step();
        check_outs("restart", 1'b1, RST_PC, 1'b0, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
